ntt_issue_ctrl: RTL and testbench

- Read-side issue controller for the in-place radix-2 forward NTT datapath (Cooley-Tukey, merged bit-reversed twiddle table).
- Walks all LOGN stages and emits per cycle one butterfly read: both coefficient addresses plus the twiddle address, qualified by rd_valid.
- Sits directly upstream of the shiftreg delay line. Downstream logic feeds rd_addr0/rd_addr1/rd_valid into shiftreg (SHIFT = PIPE_LAT) to produce the aligned write-back addresses.
- Inserts PIPE_LAT bubble cycles between stages so stage s+1 never reads a coefficient before stage s has written it.

---
 rtl/ntt_issue_ctrl_if.sv | 33 +++
 rtl/ntt_issue_ctrl.sv | 154 +++++++++++++++
 tb/tb_ntt_issue_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ntt_issue_ctrl_if.sv
// Issue-side bundle of the NTT read controller.
// master: controller side (drives status and read addresses, receives start).
// slave : consumer side (drives start, observes status and read addresses).
//   start    - begin a full transform (only honoured while idle)
//   busy     - controller not idle
//   done     - one-cycle pulse at transform completion
//   rd_valid - rd_addr0/rd_addr1/tw_addr carry a butterfly this cycle
//   rd_addr0 - even (top) coefficient address
//   rd_addr1 - odd (bottom) coefficient address
//   tw_addr  - twiddle ROM address
//   stage    - current stage index
interface ntt_issue_ctrl_if #(
  parameter int LOGN = 8
);
  logic            start;
  logic            busy;
  logic            done;
  logic            rd_valid;
  logic [LOGN-1:0] rd_addr0;
  logic [LOGN-1:0] rd_addr1;
  logic [LOGN-1:0] tw_addr;
  logic [4:0]      stage;

  modport master (
    input  start,
    output busy, done, rd_valid, rd_addr0, rd_addr1, tw_addr, stage
  );

  modport slave (
    output start,
    input  busy, done, rd_valid, rd_addr0, rd_addr1, tw_addr, stage
  );
endinterface

// File: rtl/ntt_issue_ctrl.sv
// Read-side issue controller for an in-place radix-2 forward NTT
// (Cooley-Tukey, merged bit-reversed twiddle table). Walks LOGN stages,
// issuing one butterfly read per cycle (N/2 per stage), and inserts
// PIPE_LAT bubble cycles between stages so a stage never reads a
// coefficient before the previous stage has written it back.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset
//   bus - ntt_issue_ctrl_if master modport (start in; busy, done,
//         rd_valid, rd_addr0, rd_addr1, tw_addr, stage out; all registered)
module ntt_issue_ctrl #(
  parameter int LOGN     = 8,
  parameter int PIPE_LAT = 4
) (
  input  logic                clk,
  input  logic                rst,
  ntt_issue_ctrl_if.master    bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP, DONE} state_t;

  localparam logic [4:0]      LAST_S   = 5'(LOGN - 1);
  localparam logic [7:0]      GAP_LAST = (PIPE_LAT > 0) ? 8'(PIPE_LAT - 1) : 8'd0;
  localparam logic [LOGN-1:0] ONE      = LOGN'(1);

  state_t          state;
  logic [4:0]      s;
  logic [LOGN-2:0] j;        // butterfly index within the stage: {g, i}
  logic [7:0]      gap;
  logic            valid_q;
  logic            busy_q;
  logic            done_q;
  logic [LOGN-1:0] a0_q;
  logic [LOGN-1:0] a1_q;
  logic [LOGN-1:0] tw_q;

  logic            last_j;
  logic            last_s;
  logic [4:0]      cand_s;
  logic [LOGN-2:0] cand_j;
  logic [4:0]      sh;
  logic [LOGN-1:0] jx;
  logic [LOGN-1:0] span;
  logic [LOGN-1:0] dec_i;
  logic [LOGN-1:0] dec_g;
  logic [LOGN-1:0] dec_a0;
  logic [LOGN-1:0] dec_a1;
  logic [LOGN-1:0] dec_tw;

  assign last_j = (j == '1);
  assign last_s = (s == LAST_S);

  // Coordinates of the butterfly that would be issued next, decoded ahead
  // of time so the address outputs can be registered on the issuing edge.
  // The low log2(m) bits of j are the offset i, the remaining bits the group g.
  always_comb begin
    cand_s = '0;
    cand_j = '0;
    if (state == ISSUE && !last_j) begin
      cand_s = s;
      cand_j = j + 1'b1;
    end else if (state != IDLE) begin
      cand_s = s + 5'd1;
    end
    sh     = LAST_S - cand_s;
    span   = ONE << sh;
    jx     = {1'b0, cand_j};
    dec_i  = jx & (span - ONE);
    dec_g  = jx >> sh;
    dec_a0 = (dec_g << (sh + 5'd1)) | dec_i;
    dec_a1 = dec_a0 | span;
    dec_tw = (ONE << cand_s) | dec_g;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      s       <= '0;
      j       <= '0;
      gap     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      a0_q    <= '0;
      a1_q    <= '0;
      tw_q    <= '0;
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      case (state)
        IDLE: begin
          busy_q <= 1'b0;
          if (bus.start) begin
            state   <= ISSUE;
            busy_q  <= 1'b1;
            s       <= cand_s;
            j       <= cand_j;
            valid_q <= 1'b1;
            a0_q    <= dec_a0;
            a1_q    <= dec_a1;
            tw_q    <= dec_tw;
          end
        end
        ISSUE: begin
          if (!last_j || (PIPE_LAT == 0 && !last_s)) begin
            state   <= ISSUE;
            s       <= cand_s;
            j       <= cand_j;
            valid_q <= 1'b1;
            a0_q    <= dec_a0;
            a1_q    <= dec_a1;
            tw_q    <= dec_tw;
          end else if (PIPE_LAT > 0) begin
            state <= GAP;
            gap   <= '0;
          end else begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        GAP: begin
          if (gap != GAP_LAST) begin
            gap <= gap + 8'd1;
          end else if (last_s) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            state   <= ISSUE;
            s       <= cand_s;
            j       <= cand_j;
            valid_q <= 1'b1;
            a0_q    <= dec_a0;
            a1_q    <= dec_a1;
            tw_q    <= dec_tw;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rd_valid = valid_q;
  assign bus.rd_addr0 = a0_q;
  assign bus.rd_addr1 = a1_q;
  assign bus.tw_addr  = tw_q;
  assign bus.stage    = s;

endmodule

// File: tb/tb_ntt_issue_ctrl.sv
// Bench for ntt_issue_ctrl: three instances (LOGN=3/PIPE_LAT=2,
// LOGN=3/PIPE_LAT=0, LOGN=8/PIPE_LAT=4) on a common clock.
module tb_ntt_issue_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ntt_issue_ctrl_if #(.LOGN(3)) a_if();
  ntt_issue_ctrl_if #(.LOGN(3)) b_if();
  ntt_issue_ctrl_if #(.LOGN(8)) c_if();

  ntt_issue_ctrl #(.LOGN(3), .PIPE_LAT(2)) dut_a (.clk(clk), .rst(rst), .bus(a_if.master));
  ntt_issue_ctrl #(.LOGN(3), .PIPE_LAT(0)) dut_b (.clk(clk), .rst(rst), .bus(b_if.master));
  ntt_issue_ctrl #(.LOGN(8), .PIPE_LAT(4)) dut_c (.clk(clk), .rst(rst), .bus(c_if.master));

  int checks = 0;
  int failures = 0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    bit start;
    bit valid;
    bit busy;
    bit done;
    int a0;
    int a1;
    int tw;
    int stg;   // -1: stage not checked
  } vec_t;

  vec_t tbl[0:22];

  function automatic void set_row(int c, bit st, bit v, bit b, bit d,
                                  int a0, int a1, int tw, int stg);
    tbl[c].start = st; tbl[c].valid = v; tbl[c].busy = b; tbl[c].done = d;
    tbl[c].a0 = a0; tbl[c].a1 = a1; tbl[c].tw = tw; tbl[c].stg = stg;
  endfunction

  // Scoreboards, filled from the reference equations when start is driven.
  int b_q[$];
  int c_q[$];
  int c_valid = 0;
  int seen[8][256];
  int tw_cnt[256];

  function automatic int pack(int s, int a0, int a1, int tw);
    return (s << 24) | (a0 << 16) | (a1 << 8) | tw;
  endfunction

  task automatic push_model(int logn, bit to_c);
    int n, m;
    n = 1 << logn;
    for (int s = 0; s < logn; s++) begin
      m = n >> (s + 1);
      for (int g = 0; g < (1 << s); g++)
        for (int i = 0; i < m; i++) begin
          if (to_c) c_q.push_back(pack(s, g * 2 * m + i, g * 2 * m + i + m, (1 << s) + g));
          else      b_q.push_back(pack(s, g * 2 * m + i, g * 2 * m + i + m, (1 << s) + g));
        end
    end
  endtask

  always @(negedge clk) begin
    if (b_if.rd_valid === 1'b1) begin
      if (b_q.size() == 0) check("b_extra_valid", 1, 0);
      else check("b_sb", pack(int'(b_if.stage), int'(b_if.rd_addr0), int'(b_if.rd_addr1),
                              int'(b_if.tw_addr)), b_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (c_if.rd_valid === 1'b1) begin
      c_valid++;
      if (c_q.size() == 0) check("c_extra_valid", 1, 0);
      else check("c_sb", pack(int'(c_if.stage), int'(c_if.rd_addr0), int'(c_if.rd_addr1),
                              int'(c_if.tw_addr)), c_q.pop_front());
      if (c_if.stage < 5'd8) begin
        seen[c_if.stage][c_if.rd_addr0]++;
        seen[c_if.stage][c_if.rd_addr1]++;
      end
      tw_cnt[c_if.tw_addr]++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_cyc;
    int cnt;
    int dummy;
    bit got;

    rst = 1'b1;
    a_if.start = 1'b0;
    b_if.start = 1'b0;
    c_if.start = 1'b0;

    // Run A: stage 0/1/2 sequence, gaps, ignored starts at cycles 3 and 19,
    // fresh transform from a start in cycle 21.
    set_row(0, 1, 0, 0, 0, 0, 0, 0, -1);
    for (int c = 1; c <= 4; c++) set_row(c, 0, 1, 1, 0, c - 1, c + 3, 1, 0);
    tbl[3].start = 1'b1;
    set_row(5, 0, 0, 1, 0, 0, 0, 0, 0);
    set_row(6, 0, 0, 1, 0, 0, 0, 0, 0);
    set_row(7, 0, 1, 1, 0, 0, 2, 2, 1);
    set_row(8, 0, 1, 1, 0, 1, 3, 2, 1);
    set_row(9, 0, 1, 1, 0, 4, 6, 3, 1);
    set_row(10, 0, 1, 1, 0, 5, 7, 3, 1);
    set_row(11, 0, 0, 1, 0, 0, 0, 0, 1);
    set_row(12, 0, 0, 1, 0, 0, 0, 0, 1);
    set_row(13, 0, 1, 1, 0, 0, 1, 4, 2);
    set_row(14, 0, 1, 1, 0, 2, 3, 5, 2);
    set_row(15, 0, 1, 1, 0, 4, 5, 6, 2);
    set_row(16, 0, 1, 1, 0, 6, 7, 7, 2);
    set_row(17, 0, 0, 1, 0, 0, 0, 0, 2);
    set_row(18, 0, 0, 1, 0, 0, 0, 0, 2);
    set_row(19, 1, 0, 1, 1, 0, 0, 0, -1);
    set_row(20, 0, 0, 0, 0, 0, 0, 0, -1);
    set_row(21, 1, 0, 0, 0, 0, 0, 0, -1);
    set_row(22, 0, 1, 1, 0, 0, 4, 1, 0);

    @(negedge clk);
    check("rst_a_busy", int'(a_if.busy), 0);
    check("rst_a_done", int'(a_if.done), 0);
    check("rst_a_valid", int'(a_if.rd_valid), 0);
    check("rst_a_addr0", int'(a_if.rd_addr0), 0);
    check("rst_a_addr1", int'(a_if.rd_addr1), 0);
    check("rst_a_tw", int'(a_if.tw_addr), 0);
    check("rst_a_stage", int'(a_if.stage), 0);
    check("rst_c_busy", int'(c_if.busy), 0);
    check("rst_c_valid", int'(c_if.rd_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    a_if.start = tbl[0].start;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      check($sformatf("a_valid_c%0d", c), int'(a_if.rd_valid), int'(tbl[c].valid));
      check($sformatf("a_busy_c%0d", c), int'(a_if.busy), int'(tbl[c].busy));
      check($sformatf("a_done_c%0d", c), int'(a_if.done), int'(tbl[c].done));
      if (tbl[c].valid) begin
        check($sformatf("a_addr0_c%0d", c), int'(a_if.rd_addr0), tbl[c].a0);
        check($sformatf("a_addr1_c%0d", c), int'(a_if.rd_addr1), tbl[c].a1);
        check($sformatf("a_tw_c%0d", c), int'(a_if.tw_addr), tbl[c].tw);
      end
      if (tbl[c].stg >= 0) check($sformatf("a_stage_c%0d", c), int'(a_if.stage), tbl[c].stg);
      a_if.start = tbl[c].start;
    end

    // Asynchronous reset in the middle of stage 1 of the fresh transform.
    repeat (7) @(negedge clk);
    check("arst_pre_valid", int'(a_if.rd_valid), 1);
    check("arst_pre_stage", int'(a_if.stage), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", int'(a_if.rd_valid), 0);
    check("arst_busy", int'(a_if.busy), 0);
    check("arst_done", int'(a_if.done), 0);
    check("arst_stage", int'(a_if.stage), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("arst_post_done", int'(a_if.done), 0);
      check("arst_post_busy", int'(a_if.busy), 0);
    end
    a_if.start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      a_if.start = 1'b0;
      check($sformatf("arst_s0_valid_%0d", c), int'(a_if.rd_valid), 1);
      check($sformatf("arst_s0_addr0_%0d", c), int'(a_if.rd_addr0), c - 1);
      check($sformatf("arst_s0_addr1_%0d", c), int'(a_if.rd_addr1), c + 3);
      check($sformatf("arst_s0_tw_%0d", c), int'(a_if.tw_addr), 1);
    end
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (a_if.busy == 1'b0) got = 1'b1;
    end
    check("a_idle_after_rst_run", int'(got), 1);

    // start tied high: done at 19 and 39, one IDLE cycle at 20 and 40.
    a_if.start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      check($sformatf("tied_done_c%0d", c), int'(a_if.done), int'(c == 19 || c == 39));
      check($sformatf("tied_busy_c%0d", c), int'(a_if.busy), int'(!(c == 20 || c == 40)));
      if (c == 1 || c == 21) begin
        check($sformatf("tied_valid_c%0d", c), int'(a_if.rd_valid), 1);
        check($sformatf("tied_addr1_c%0d", c), int'(a_if.rd_addr1), 4);
      end
    end
    a_if.start = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (a_if.busy == 1'b0) got = 1'b1;
    end
    check("a_idle_after_tied", int'(got), 1);

    // Run B: PIPE_LAT=0, 12 back-to-back issues, done at cycle 13.
    push_model(3, 1'b0);
    b_if.start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      b_if.start = 1'b0;
      check($sformatf("b_valid_c%0d", c), int'(b_if.rd_valid), int'(c <= 12));
      check($sformatf("b_done_c%0d", c), int'(b_if.done), int'(c == 13));
      check($sformatf("b_busy_c%0d", c), int'(b_if.busy), int'(c <= 13));
    end
    check("b_queue_left", b_q.size(), 0);

    // Run C: LOGN=8, PIPE_LAT=4 against the scoreboard.
    push_model(8, 1'b1);
    c_if.start = 1'b1;
    done_cyc = -1;
    cnt = 0;
    for (int c = 1; c <= 1200 && done_cyc < 0; c++) begin
      @(negedge clk);
      c_if.start = 1'b0;
      if (c_if.done) begin
        done_cyc = c;
        cnt++;
      end
    end
    check("c_done_cycle", done_cyc, 1 + 8 * 132);
    @(negedge clk);
    check("c_busy_after_done", int'(c_if.busy), 0);
    check("c_done_once", cnt + int'(c_if.done), 1);
    check("c_valid_count", c_valid, 1024);
    check("c_queue_left", c_q.size(), 0);
    for (int s = 0; s < 8; s++)
      for (int a = 0; a < 256; a++)
        check($sformatf("c_cover_s%0d_a%0d", s, a), seen[s][a], 1);
    check("c_tw0_unused", tw_cnt[0], 0);
    for (int t = 1; t < 256; t++) begin
      dummy = 0;
      for (int k = 0; k < 8; k++) if ((t >> k) != 0) dummy = k;
      check($sformatf("c_tw_cnt_%0d", t), tw_cnt[t], 1 << (7 - dummy));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
